conv_window_scheduler: RTL
==========================

Name: conv_window_scheduler

Overview:
Control block for the 7x7 IFM / 3x3 weight convolution datapath.
- Generates write strobes and addresses for the IFM buffer (49 x 16b) and the weight buffer (9 x 16b).
- Once both buffers are full, issues the 25 window base addresses in raster order to the MAC datapath through a valid/ready handshake.
- Replaces the free-running output counter with a stall-tolerant scheduler.

Parameters:
IFM_W, 7, IFM row/column size
K, 3, kernel size
OUT_W, IFM_W-K+1 (5), output row/column size (derived, not overridable)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  IFM beat valid, one pixel per cycle
weight_valid  in  1  weight beat valid, one weight per cycle
ifm_we  out  1  IFM buffer write enable (combinational from in_valid and state)
ifm_addr  out  6  IFM buffer write address
wgt_we  out  1  weight buffer write enable (combinational)
wgt_addr  out  4  weight buffer write address
win_valid  out  1  window base valid
win_ready  in  1  datapath accepts window
win_base  out  6  top-left IFM index of current window
win_last  out  1  current window is the 25th
busy  out  1  high in LOAD or COMPUTE
done  out  1  one-cycle pulse after last window accepted
err  out  1  sticky protocol error

Behaviour:
Reset values:
- State IDLE; all counters 0.
- win_valid=0, win_base=0, win_last=0, busy=0, done=0, err=0.
- Reset mid-operation aborts immediately. Buffer contents are not touched.

FSM states: IDLE, LOAD, COMPUTE, DONE.

IDLE:
- First in_valid or weight_valid moves to LOAD.
- That beat is written in the same cycle: ifm_we/wgt_we are asserted combinationally in IDLE and LOAD.
- Entering LOAD clears err.

LOAD:
- ifm_cnt (0..49) and wgt_cnt (0..9) count independently.
- ifm_we = in_valid && ifm_cnt<49, with ifm_addr=ifm_cnt. wgt_we and wgt_addr follow the same rule with wgt_cnt<9.
- Both streams may be active in the same cycle.
- Beats beyond 49 IFM or 9 weights are dropped and set err.
- When ifm_cnt==49 and wgt_cnt==9 at a clock edge, go to COMPUTE. win_valid rises the next cycle with win_base=0.

COMPUTE:
- win_valid is held high and win_base is held stable until win_ready.
- On each handshake (win_valid && win_ready):
  - If col==OUT_W-1: col=0 and base += K.
  - Otherwise: col+=1 and base+=1.
- Base sequence: 0..4, 7..11, 14..18, 21..25, 28..32.
- win_last=1 exactly when base==32.
- Handshake while win_last=1: go to DONE and drop win_valid the next cycle.
- in_valid or weight_valid during COMPUTE or DONE: ignored (no write) and sets err.

DONE:
- done=1 for one cycle.
- Counters clear; go to IDLE.
- A new load may begin the following cycle.

Throughput: one window per cycle when win_ready is held high.
- Latency from the final load beat to the first win_valid: 2 cycles (edge into COMPUTE, then registered valid).

Widths: all counters saturate at their terminal value and never wrap.

Optional Feature:
CONV_STALL_CNT_EN
- Defined: adds output stall_cnt (16b).
  - Counts cycles with win_valid && !win_ready during the current COMPUTE, saturating at 0xFFFF.
  - Cleared on entering COMPUTE; holds its value after DONE.
- Undefined: no port and no logic.

Decomposition:
- Shared package conv_pkg holds:
  - IFM_W, K, OUT_W, IFM_DEPTH=49, WGT_DEPTH=9 constants.
  - State enum conv_state_t.
  - LAST_BASE=(OUT_W-1)*(IFM_W+1).
- One sub-module, conv_win_addr_gen:
  - Row/col counters and base/last generation.
  - Advance input = handshake.
- Top-level holds the FSM, load counters and err.

Test Plan:
1. Interleaved load: 49 in_valid and 9 weight_valid beats, weights on cycles 0-8 overlapping IFM.
   -> addresses 0..48 and 0..8, each written once.
   -> win_valid 2 cycles after the 49th IFM beat, win_base=0.
2. win_ready tied high -> 25 consecutive bases 0,1,2,3,4,7,...,32; win_last only on 32; done pulses one cycle after.
3. Random win_ready (about 50%) -> win_base stable while !win_ready; same 25-base sequence; no skips or duplicates.
4. 52 IFM beats -> beats 50-52 not written (ifm_we=0); err=1; it stays set until the next load starts.
5. in_valid during COMPUTE at window 10 -> no write, err=1, window sequence unaffected.
6. rst_n asserted at window 12 -> all outputs 0 immediately; a fresh full load then produces the full 25-window sequence from base 0.
   With CONV_STALL_CNT_EN: 3 stall cycles -> stall_cnt=3.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and state type for the 7x7 IFM / 3x3 kernel convolution window scheduler.
package conv_pkg;

    localparam int IFM_W     = 7;
    localparam int K         = 3;
    localparam int OUT_W     = IFM_W - K + 1;
    localparam int IFM_DEPTH = IFM_W * IFM_W;
    localparam int WGT_DEPTH = K * K;
    // Top-left index of the bottom-right window: (OUT_W-1) rows down plus (OUT_W-1) columns across.
    localparam int LAST_BASE = (OUT_W - 1) * (IFM_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_DONE    = 2'd3
    } conv_state_t;

endpackage

// File: rtl/conv_window_scheduler_if.sv
// Load/window handshake bundle between the convolution scheduler and its buffers/MAC datapath.
interface conv_window_scheduler_if;

    logic       in_valid;
    logic       weight_valid;
    logic       ifm_we;
    logic [5:0] ifm_addr;
    logic       wgt_we;
    logic [3:0] wgt_addr;
    logic       win_valid;
    logic       win_ready;
    logic [5:0] win_base;
    logic       win_last;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        input  in_valid, weight_valid, win_ready,
        output ifm_we, ifm_addr, wgt_we, wgt_addr,
               win_valid, win_base, win_last, busy, done, err
    );

    modport slave (
        output in_valid, weight_valid, win_ready,
        input  ifm_we, ifm_addr, wgt_we, wgt_addr,
               win_valid, win_base, win_last, busy, done, err
    );

endinterface

// File: rtl/conv_win_addr_gen.sv
// Raster-order window base generator: column counter plus running top-left IFM index.
module conv_win_addr_gen
    import conv_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       advance,
    output logic [5:0] base,
    output logic       last
);

    localparam logic [2:0] COL_TC   = 3'(OUT_W - 1);
    localparam logic [5:0] BASE_TC  = 6'(LAST_BASE);
    localparam logic [5:0] ROW_STEP = 6'(K);

    logic [2:0] col;

    assign last = (base == BASE_TC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col  <= '0;
            base <= '0;
        end else if (clear) begin
            col  <= '0;
            base <= '0;
        end else if (advance && !last) begin
            // Wrapping to the next row skips the K-1 columns no window can start in.
            if (col == COL_TC) begin
                col  <= '0;
                base <= base + ROW_STEP;
            end else begin
                col  <= col + 3'd1;
                base <= base + 6'd1;
            end
        end
    end

endmodule

// File: rtl/conv_window_scheduler.sv
// Buffer-load and window-issue controller for the convolution datapath.
// Build option: define CONV_STALL_CNT_EN to add the 16-bit stall_cnt output.
//
// state      | meaning
// IDLE       | waiting for the first IFM or weight beat (which is written immediately)
// LOAD       | filling IFM (49) and weight (9) buffers, streams counted independently
// COMPUTE    | issuing 25 window bases over valid/ready
// DONE       | one-cycle done pulse, load counters cleared
module conv_window_scheduler
    import conv_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    conv_window_scheduler_if.master  bus
`ifdef CONV_STALL_CNT_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);

    localparam logic [5:0] IFM_TC = 6'(IFM_DEPTH);
    localparam logic [3:0] WGT_TC = 4'(WGT_DEPTH);

    conv_state_t state, state_nxt;

    logic [5:0] ifm_cnt;
    logic [3:0] wgt_cnt;
    logic       ifm_we, wgt_we, win_valid, busy, done, err;
    logic       hs, load_start, overflow, stray;
    logic [5:0] win_base;
    logic       base_last;

    assign hs = win_valid && bus.win_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (bus.in_valid || bus.weight_valid) state_nxt = ST_LOAD;
            ST_LOAD:    if (ifm_cnt == IFM_TC && wgt_cnt == WGT_TC) state_nxt = ST_COMPUTE;
            ST_COMPUTE: if (hs && base_last) state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ifm_we    = 1'b0;
        wgt_we    = 1'b0;
        win_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                ifm_we = bus.in_valid;
                wgt_we = bus.weight_valid;
            end
            ST_LOAD: begin
                ifm_we = bus.in_valid && (ifm_cnt != IFM_TC);
                wgt_we = bus.weight_valid && (wgt_cnt != WGT_TC);
                busy   = 1'b1;
            end
            ST_COMPUTE: begin
                win_valid = 1'b1;
                busy      = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifm_cnt <= '0;
            wgt_cnt <= '0;
        end else if (state == ST_DONE) begin
            ifm_cnt <= '0;
            wgt_cnt <= '0;
        end else begin
            if (ifm_we) ifm_cnt <= ifm_cnt + 6'd1;
            if (wgt_we) wgt_cnt <= wgt_cnt + 4'd1;
        end
    end

    assign load_start = (state == ST_IDLE) && (bus.in_valid || bus.weight_valid);
    assign overflow   = (state == ST_LOAD) &&
                        ((bus.in_valid && ifm_cnt == IFM_TC) ||
                         (bus.weight_valid && wgt_cnt == WGT_TC));
    assign stray      = ((state == ST_COMPUTE) || (state == ST_DONE)) &&
                        (bus.in_valid || bus.weight_valid);

    // err survives DONE/IDLE so software can see it; only a fresh load clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 err <= 1'b0;
        else if (load_start)        err <= 1'b0;
        else if (overflow || stray) err <= 1'b1;
    end

    conv_win_addr_gen u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state != ST_COMPUTE),
        .advance (hs),
        .base    (win_base),
        .last    (base_last)
    );

`ifdef CONV_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (state == ST_LOAD && state_nxt == ST_COMPUTE)
            stall_cnt <= '0;
        else if (win_valid && !bus.win_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

    assign bus.ifm_we    = ifm_we;
    assign bus.ifm_addr  = ifm_cnt;
    assign bus.wgt_we    = wgt_we;
    assign bus.wgt_addr  = wgt_cnt;
    assign bus.win_valid = win_valid;
    assign bus.win_base  = win_base;
    assign bus.win_last  = win_valid && base_last;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.err       = err;

endmodule
